// File: rtl/gyro_if.sv
// Sensor-side SPI pins, sample outputs and debug state of the gyro sequencer.
interface gyro_if;
  logic        gyro_cs;
  logic        gyro_sclk;
  logic        gyro_mosi;
  logic        gyro_miso;
  logic [15:0] data_x;
  logic [15:0] data_y;
  logic [15:0] data_z;
  // valid is a one-cycle strobe with no ready: data_x/y/z change only on the
  // cycle valid is high and must be taken then; there is no backpressure.
  logic        valid;
  logic        init_done;
  logic        busy;
  logic [2:0]  dbg_state;
  logic [2:0]  dbg_phase;

  modport master (
    output gyro_cs, gyro_sclk, gyro_mosi,
    input  gyro_miso,
    output data_x, data_y, data_z, valid, init_done, busy,
    output dbg_state, dbg_phase
  );

  modport slave (
    input  gyro_cs, gyro_sclk, gyro_mosi,
    output gyro_miso,
    input  data_x, data_y, data_z, valid, init_done, busy,
    input  dbg_state, dbg_phase
  );
endinterface

// File: rtl/gyro_sequencer.sv
// Configures a 3-axis SPI gyro once after reset, then periodically burst-reads
// the six rate registers and presents them as signed X/Y/Z samples.
module gyro_sequencer #(
  parameter int CLK_DIV       = 50,
  parameter int SAMPLE_PERIOD = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  gyro_if.master bus
);

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int PER_W = $clog2(SAMPLE_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [15:0] CFG_WORD  = 16'h200F;
  localparam logic [15:0] READ_WORD = 16'hE800;
  localparam logic [5:0]  CFG_LAST_BIT  = 6'd15;
  localparam logic [5:0]  READ_LAST_BIT = 6'd55;

  typedef enum logic [2:0] {
    ST_CFG  = 3'd0,
    ST_GAP  = 3'd1,
    ST_IDLE = 3'd2,
    ST_READ = 3'd3,
    ST_LOAD = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    PH_START = 3'd0,
    PH_SETUP = 3'd1,
    PH_LOW   = 3'd2,
    PH_HIGH  = 3'd3,
    PH_HOLD  = 3'd4
  } phase_t;

  state_t           r_state;
  phase_t           r_phase;
  logic [DIV_W-1:0] r_div_cnt;
  logic [PER_W-1:0] r_per_cnt;
  logic             r_per_run;
  logic [5:0]       r_bit_cnt;
  logic [5:0]       r_last_bit;
  logic [15:0]      r_tx;
  logic [47:0]      r_rx;
  logic             r_cs;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_busy;
  logic             r_valid;
  logic             r_init_done;
  logic [15:0]      r_data_x;
  logic [15:0]      r_data_y;
  logic [15:0]      r_data_z;

  logic w_div_end;
  logic w_per_wrap;

  assign w_div_end  = (r_div_cnt == DIV_LAST);
  assign w_per_wrap = r_per_run && (r_per_cnt == PER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_CFG;
      r_phase     <= PH_START;
      r_div_cnt   <= '0;
      r_per_cnt   <= '0;
      r_per_run   <= 1'b0;
      r_bit_cnt   <= '0;
      r_last_bit  <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_cs        <= 1'b1;
      r_sclk      <= 1'b1;
      r_mosi      <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_init_done <= 1'b0;
      r_data_x    <= '0;
      r_data_y    <= '0;
      r_data_z    <= '0;
    end else begin
      r_valid <= 1'b0;
      // The sample period keeps running outside IDLE; wraps seen there are dropped.
      if (r_per_run) r_per_cnt <= w_per_wrap ? '0 : r_per_cnt + 1'b1;

      case (r_state)
        ST_CFG, ST_READ: begin
          case (r_phase)
            PH_START: begin
              r_cs       <= 1'b0;
              r_busy     <= 1'b1;
              r_tx       <= CFG_WORD;
              r_last_bit <= CFG_LAST_BIT;
              r_bit_cnt  <= '0;
              r_div_cnt  <= '0;
              r_phase    <= PH_SETUP;
            end
            PH_SETUP, PH_HIGH: begin
              if (w_div_end) begin
                r_div_cnt <= '0;
                r_sclk    <= 1'b0;
                r_mosi    <= r_tx[15];
                r_tx      <= {r_tx[14:0], 1'b0};
                r_phase   <= PH_LOW;
              end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
              end
            end
            PH_LOW: begin
              if (w_div_end) begin
                r_div_cnt <= '0;
                r_sclk    <= 1'b1;
                r_rx      <= {r_rx[46:0], bus.gyro_miso};
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_phase   <= (r_bit_cnt == r_last_bit) ? PH_HOLD : PH_HIGH;
              end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
              end
            end
            PH_HOLD: begin
              if (w_div_end) begin
                r_div_cnt <= '0;
                r_cs      <= 1'b1;
                r_busy    <= 1'b0;
                r_mosi    <= 1'b0;
                r_phase   <= PH_START;
                r_state   <= (r_state == ST_CFG) ? ST_GAP : ST_LOAD;
              end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
              end
            end
            default: r_phase <= PH_START;
          endcase
        end
        ST_LOAD: begin
          // Bytes arrive XL,XH,YL,YH,ZL,ZH, so the oldest byte sits at the top.
          r_data_x  <= {r_rx[39:32], r_rx[47:40]};
          r_data_y  <= {r_rx[23:16], r_rx[31:24]};
          r_data_z  <= {r_rx[7:0],   r_rx[15:8]};
          r_valid   <= 1'b1;
          r_div_cnt <= '0;
          r_state   <= ST_GAP;
        end
        ST_GAP: begin
          if (r_div_cnt == GAP_LAST) begin
            r_div_cnt   <= '0;
            r_init_done <= 1'b1;
            r_per_run   <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_per_wrap) begin
            r_cs       <= 1'b0;
            r_busy     <= 1'b1;
            r_tx       <= READ_WORD;
            r_last_bit <= READ_LAST_BIT;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            r_phase    <= PH_SETUP;
            r_state    <= ST_READ;
          end
        end
        default: r_state <= ST_CFG;
      endcase
    end
  end

  assign bus.gyro_cs   = r_cs;
  assign bus.gyro_sclk = r_sclk;
  assign bus.gyro_mosi = r_mosi;
  assign bus.data_x    = r_data_x;
  assign bus.data_y    = r_data_y;
  assign bus.data_z    = r_data_z;
  assign bus.valid     = r_valid;
  assign bus.init_done = r_init_done;
  assign bus.busy      = r_busy;
  assign bus.dbg_state = r_state;
  assign bus.dbg_phase = r_phase;

endmodule

// File: tb/tb_gyro_sequencer.sv
// Bench for gyro_sequencer: SPI slave model, protocol checker and a sample
// scoreboard fed by directed read responses.
module tb_gyro_sequencer;

  localparam int CLK_DIV       = 2;
  localparam int SAMPLE_PERIOD = 400;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic miso_r = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gyro_if bus ();
  assign bus.gyro_miso = miso_r;

  gyro_sequencer #(
    .CLK_DIV       (CLK_DIV),
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          valid_cnt = 0;
  logic [47:0] exp_q[$];
  logic [47:0] resp_q[$];
  logic [63:0] cmd_q[$];
  int          rd_fall[$];
  logic [47:0] model_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue_cfg();
    cmd_q.push_back({8'd16, 40'h0, 16'h200F});
  endtask

  task automatic issue_read(input logic [47:0] frame, input logic [47:0] exp, input bit completes);
    resp_q.push_back(frame);
    if (completes) begin
      cmd_q.push_back({8'd56, 8'hE8, 48'h0});
      exp_q.push_back(exp);
    end
  endtask

  task automatic release_and_cfg();
    int n;
    @(negedge clk);
    #2 rst = 1'b0;
    n = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) chk("first_cs_fall", bus.gyro_cs, 1'b0);
      if (bus.init_done) begin
        n = c;
        break;
      end
    end
    chk("init_done_cycle", n, 1 + 35 * CLK_DIV);
    chk("init_done_level", bus.init_done, 1'b1);
  endtask

  task automatic wait_valid(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (valid_cnt >= n) break;
      @(negedge clk);
    end
    chk("valid_count", valid_cnt, n);
  endtask

  // ---------------- SPI slave model ----------------
  logic [55:0] s_word  = '0;
  logic [47:0] s_frame = '0;
  int          s_rise  = 0;
  int          s_fall  = 0;
  logic        ps_cs   = 1'b1;
  logic        ps_sclk = 1'b1;

  always @(bus.gyro_cs or bus.gyro_sclk or rst) begin
    if (rst || (ps_cs && !bus.gyro_cs)) begin
      s_rise  = 0;
      s_fall  = 0;
      s_word  = '0;
      s_frame = '0;
      miso_r  = 1'b0;
    end else if (!ps_cs && bus.gyro_cs) begin
      if (cmd_q.size() == 0) fail_now("spi_cmd_unexpected");
      else chk("spi_cmd", {8'(s_rise), s_word}, cmd_q.pop_front());
      miso_r = 1'b0;
    end else if (!bus.gyro_cs && !ps_sclk && bus.gyro_sclk) begin
      s_word = {s_word[54:0], bus.gyro_mosi};
      s_rise++;
      if (s_rise == 8 && s_word[7:0] == 8'hE8 && resp_q.size() > 0) s_frame = resp_q.pop_front();
    end else if (!bus.gyro_cs && ps_sclk && !bus.gyro_sclk) begin
      if (s_fall >= 8 && s_fall < 56) miso_r = s_frame[47 - (s_fall - 8)];
      else miso_r = 1'b0;
      s_fall++;
    end
    ps_cs   = bus.gyro_cs;
    ps_sclk = bus.gyro_sclk;
  end

  // ---------------- protocol checker ----------------
  logic p_cs = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0;
  int   since_edge = 0, gap_len = 0;
  bit   first_pending = 1'b0, skip_gap = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      p_cs = 1'b1; p_sclk = 1'b1; p_mosi = 1'b0;
      since_edge = 0; gap_len = 0; first_pending = 1'b0; skip_gap = 1'b1;
    end else begin
      since_edge++;
      gap_len++;
      chk("busy_vs_cs", bus.busy, !bus.gyro_cs);
      if (bus.gyro_cs) begin
        chk("sclk_high_when_cs_high", bus.gyro_sclk, 1'b1);
        chk("mosi_low_when_cs_high", bus.gyro_mosi, 1'b0);
      end
      if (p_cs && !bus.gyro_cs) begin
        if (!skip_gap) chk("cs_gap_min", gap_len >= 2 * CLK_DIV, 1'b1);
        skip_gap = 1'b0;
        first_pending = 1'b1;
        since_edge = 0;
        if (bus.init_done) rd_fall.push_back(cyc);
      end else if (!p_cs && bus.gyro_cs) begin
        chk("cs_hold", since_edge, CLK_DIV);
        gap_len = 0;
        since_edge = 0;
      end else if (!bus.gyro_cs) begin
        if (p_sclk && !bus.gyro_sclk) begin
          if (first_pending) chk("cs_setup", since_edge, CLK_DIV);
          else chk("sclk_high_len", since_edge, CLK_DIV);
          first_pending = 1'b0;
          since_edge = 0;
        end else if (!p_sclk && bus.gyro_sclk) begin
          chk("sclk_low_len", since_edge, CLK_DIV);
          since_edge = 0;
        end else begin
          chk("mosi_stable", bus.gyro_mosi, p_mosi);
        end
      end
      p_cs = bus.gyro_cs; p_sclk = bus.gyro_sclk; p_mosi = bus.gyro_mosi;
    end
  end

  // ---------------- sample monitor ----------------
  logic [47:0] got;
  logic [47:0] want;
  logic        pv = 1'b0;

  always @(negedge clk) begin
    got = {bus.data_x, bus.data_y, bus.data_z};
    if (rst) begin
      model_data = '0;
      pv = 1'b0;
      chk("data_in_reset", got, 48'h0);
      chk("valid_in_reset", bus.valid, 1'b0);
    end else begin
      if (bus.valid) begin
        chk("valid_width", pv, 1'b0);
        valid_cnt++;
        if (exp_q.size() == 0) begin
          fail_now("valid_unexpected");
        end else begin
          want = exp_q.pop_front();
          chk("sample_xyz", got, want);
          model_data = want;
        end
      end else begin
        chk("data_hold", got, model_data);
      end
      pv = bus.valid;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    #1 rst = 1'b1;
    issue_cfg();
    issue_read(48'h3412_7856_BC9A, 48'h1234_5678_9ABC, 1'b1);
    issue_read(48'hFF7F_0080_FFFF, 48'h7FFF_8000_FFFF, 1'b1);
    issue_read(48'h0180_FE7F_55AA, 48'h8001_7FFE_AA55, 1'b1);
    issue_read(48'hDEAD_BEEF_CAFE, 48'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_cs", bus.gyro_cs, 1'b1);
    chk("rst_sclk", bus.gyro_sclk, 1'b1);
    chk("rst_mosi", bus.gyro_mosi, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_init_done", bus.init_done, 1'b0);
    chk("rst_state", bus.dbg_state, 3'd0);

    release_and_cfg();
    wait_valid(3, 3000);
    if (rd_fall.size() < 3) begin
      fail_now("read_fall_count");
    end else begin
      chk("read_interval_1", rd_fall[1] - rd_fall[0], SAMPLE_PERIOD);
      chk("read_interval_2", rd_fall[2] - rd_fall[1], SAMPLE_PERIOD);
    end

    // Abort the fourth read while its 30th bit is being clocked.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (s_rise == 29 && !bus.gyro_sclk && !bus.gyro_cs) break;
    end
    chk("abort_point_reached", s_rise, 29);
    #2 rst = 1'b1;
    #1;
    chk("abort_cs", bus.gyro_cs, 1'b1);
    chk("abort_sclk", bus.gyro_sclk, 1'b1);
    chk("abort_mosi", bus.gyro_mosi, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_init_done", bus.init_done, 1'b0);
    chk("abort_data", {bus.data_x, bus.data_y, bus.data_z}, 48'h0);
    chk("abort_state", bus.dbg_state, 3'd0);
    if (rd_fall.size() < 4) fail_now("read_fall_count_4");
    else chk("read_interval_3", rd_fall[3] - rd_fall[2], SAMPLE_PERIOD);
    repeat (3) @(negedge clk);

    issue_cfg();
    issue_read(48'h0000_FF00_0102, 48'h0000_00FF_0201, 1'b1);
    release_and_cfg();
    chk("no_valid_on_abort", valid_cnt, 3);
    wait_valid(4, 1500);
    repeat (10) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("cmd_q_drained", cmd_q.size(), 0);
    chk("resp_q_drained", resp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gyro_sequencer.md
GYRO_SEQUENCER -- requirements
Module: gyro_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 50, meaning clk cycles per SCLK half-period (legal range >= 2).
REQ-002 Parameter SAMPLE_PERIOD, default 1_000_000, meaning clk cycles between read-transaction starts (legal only if > 150*CLK_DIV).
REQ-003 Port clk  input  1  meaning sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 Port gyro_cs  output  1  meaning SPI chip select, active low.
REQ-006 Port gyro_sclk  output  1  meaning SPI clock, mode 3 (CPOL=1, CPHA=1).
REQ-007 Port gyro_mosi  output  1  meaning SPI data to sensor, MSB first.
REQ-008 Port gyro_miso  input  1  meaning SPI data from sensor, MSB first.
REQ-009 Port data_x / data_y / data_z  output  16 each  meaning latest signed angular-rate samples.
REQ-010 Port valid  output  1  meaning one-cycle pulse when data_x/y/z update.
REQ-011 Port init_done  output  1  meaning sensor configuration complete.
REQ-012 Port busy  output  1  meaning a transaction is in progress (gyro_cs low or in CS setup/hold).

Function
REQ-013 FSM states: CFG, GAP, IDLE, READ, LOAD; CFG and READ share one bit-shift engine.
REQ-014 CFG: one 16-bit write transaction, byte0 = 8'h20 (write, no auto-increment, CTRL_REG1), byte1 = 8'h0F (power on, X/Y/Z enabled).
REQ-015 After the CFG transaction, go to GAP, then IDLE, and set init_done = 1; init_done stays 1 until reset.
REQ-016 IDLE: a free-running period counter (0..SAMPLE_PERIOD-1, wraps) starts READ on wrap; counter starts at 0 when IDLE is first entered.
REQ-017 READ: one 56-bit transaction, byte0 = 8'hE8 (read, auto-increment, OUT_X_L), then 48 bits clocked with gyro_mosi = 0.
REQ-018 Byte assembly: received bytes in order XL, XH, YL, YH, ZL, ZH; data_x = {XH,XL}, data_y = {YH,YL}, data_z = {ZH,ZL}.
REQ-019 LOAD: all three outputs update on the same clk edge, with valid high for exactly that one cycle; then GAP, then IDLE.
REQ-020 Outputs hold their values between LOAD cycles; a partial read never alters data_x/y/z.
REQ-021 Transaction timing: gyro_cs falls, CLK_DIV cycles setup, then per bit: gyro_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-022 gyro_mosi changes only on the clk edge where gyro_sclk falls; gyro_miso is sampled on the clk edge where gyro_sclk rises.
REQ-023 After the last rising SCLK edge, hold CLK_DIV cycles with gyro_sclk = 1, then raise gyro_cs.
REQ-024 GAP: gyro_cs high and gyro_sclk high for 2*CLK_DIV cycles before any further transaction.
REQ-025 gyro_sclk is 1 whenever gyro_cs = 1; gyro_mosi is 0 whenever gyro_cs = 1.
REQ-026 A period wrap occurring while not in IDLE is ignored (no queued read); the next read is on the following wrap.
REQ-027 busy = 1 from the gyro_cs fall through the gyro_cs rise inclusive of setup/hold, 0 otherwise.

Reset
REQ-028 On rst high, immediately: gyro_cs = 1, gyro_sclk = 1, gyro_mosi = 0, data_x/y/z = 0, valid = 0, init_done = 0, busy = 0, all counters 0, state = CFG.
REQ-029 Reset asserted mid-transaction aborts the transaction at once with no output update; after release the sequence restarts with CFG.
REQ-030 The first gyro_cs fall occurs on the first clk edge after rst deasserts.

Verification
REQ-031 Reset release, CLK_DIV=2 -> gyro_cs low, 16 SCLK pulses with mosi bits 0x20,0x0F; gyro_cs high; init_done = 1 after GAP.
REQ-032 SPI slave model returns 34 12 78 56 BC 9A after 0xE8 -> data_x=16'h1234, data_y=16'h5678, data_z=16'h9ABC; exactly one valid pulse per transaction.
REQ-033 SAMPLE_PERIOD=400, CLK_DIV=2 -> consecutive gyro_cs falls of READ transactions are exactly 400 clk cycles apart; 56 SCLK rising edges per read.
REQ-034 rst pulse during the 30th bit of a read -> gyro_cs = 1, gyro_sclk = 1 asynchronously, data_x/y/z = 0, no valid pulse, then CFG write repeats.
REQ-035 Protocol checker throughout -> mosi stable while sclk high, cs-to-first-fall >= CLK_DIV, cs-high gap >= 2*CLK_DIV, sclk = 1 whenever cs = 1.
REQ-036 Slave returns FF 7F 00 80 FF FF -> data_x=16'h7FFF, data_y=16'h8000, data_z=16'hFFFF (sign bits preserved).
